// File: rtl/microcode_pkg.sv
// Shared constants for the microcode sequencer: control-word field
// positions, widths, the CB prefix byte and FSM state encodings.
package microcode_pkg;

  localparam int UOP_ADDR_W = 9;
  localparam int CTRL_W     = 64;

  // Control-word bit positions
  localparam int UC_DONE      = 63;
  localparam int UC_NEXT_HI   = 62;
  localparam int UC_NEXT_LO   = 54;
  localparam int UC_FETCH_IMM = 53;
  localparam int UC_HALT      = 52;

  localparam logic [7:0] CB_PREFIX = 8'hCB;

  // Sequencer states
  localparam logic [2:0] S_FETCH_OP  = 3'd0;
  localparam logic [2:0] S_FETCH_CB  = 3'd1;
  localparam logic [2:0] S_EXEC      = 3'd2;
  localparam logic [2:0] S_FETCH_IMM = 3'd3;
  localparam logic [2:0] S_HALTED    = 3'd4;

  // Next micro-op address carried in a control word
  function automatic logic [UOP_ADDR_W-1:0] uc_next(input logic [CTRL_W-1:0] w);
    return w[UC_NEXT_HI:UC_NEXT_LO];
  endfunction

endpackage

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: fetches opcode / CB-prefixed opcode / immediate
// bytes, drives the ROM address and walks micro-op chains through the
// next-address field, presenting each micro-op with a valid/stall handshake.
module microcode_sequencer
  import microcode_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  input  logic [7:0]  fetch_data,
  output logic [8:0]  uop_addr,
  input  logic [63:0] uop_ctrl,
  output logic        uop_valid,
  input  logic        stall,
  output logic [15:0] imm,
  output logic        instr_start,
  output logic        instr_done,
  input  logic        wake
);

  logic [2:0]  state_q, state_d;
  logic [8:0]  uop_addr_q, uop_addr_d;
  logic [15:0] imm_q, imm_d;
  logic        imm_taken_q, imm_taken_d;
  // Low while in reset and for the first clock after it, so no fetch is
  // requested before the core has seen a clean edge.
  logic        started_q, started_d;

  logic need_imm;
  assign need_imm = uop_ctrl[UC_FETCH_IMM] && !imm_taken_q;

  // Datapath-owned fields of the control word are not used here.
  logic unused_ctrl;
  assign unused_ctrl = ^uop_ctrl[UC_HALT-1:0];

  // Next-state, handshake outputs and byte capture
  always_comb begin
    state_d     = state_q;
    uop_addr_d  = uop_addr_q;
    imm_d       = imm_q;
    imm_taken_d = imm_taken_q;
    started_d   = 1'b1;
    fetch_valid = 1'b0;
    uop_valid   = 1'b0;
    instr_start = 1'b0;
    instr_done  = 1'b0;
    case (state_q)
      S_FETCH_OP: begin
        fetch_valid = started_q;
        if (started_q && fetch_ready) begin
          instr_start = 1'b1;
          imm_d       = 16'h0000;
          if (fetch_data == CB_PREFIX) begin
            state_d = S_FETCH_CB;
          end else begin
            uop_addr_d = {1'b0, fetch_data};
            state_d    = S_EXEC;
          end
        end
      end
      S_FETCH_CB: begin
        fetch_valid = 1'b1;
        // Any byte after the prefix, including another CB, is an opcode
        if (fetch_ready) begin
          uop_addr_d = {1'b1, fetch_data};
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        if (need_imm) begin
          state_d = S_FETCH_IMM;
        end else begin
          uop_valid = 1'b1;
          if (!stall) begin
            imm_taken_d = 1'b0;
            // HALT takes priority over DONE when both are set
            if (uop_ctrl[UC_HALT]) begin
              instr_done = 1'b1;
              state_d    = S_HALTED;
            end else if (uop_ctrl[UC_DONE]) begin
              instr_done = 1'b1;
              state_d    = S_FETCH_OP;
            end else begin
              uop_addr_d = uc_next(uop_ctrl);
            end
          end
        end
      end
      S_FETCH_IMM: begin
        fetch_valid = 1'b1;
        // Little-endian: bytes shift in from the top
        if (fetch_ready) begin
          imm_d       = {fetch_data, imm_q[15:8]};
          imm_taken_d = 1'b1;
          state_d     = S_EXEC;
        end
      end
      S_HALTED: begin
        if (wake) state_d = S_FETCH_OP;
      end
      default: state_d = S_FETCH_OP;
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FETCH_OP;
      uop_addr_q  <= '0;
      imm_q       <= '0;
      imm_taken_q <= 1'b0;
      started_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      uop_addr_q  <= uop_addr_d;
      imm_q       <= imm_d;
      imm_taken_q <= imm_taken_d;
      started_q   <= started_d;
    end
  end

  assign uop_addr = uop_addr_q;
  assign imm      = imm_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Scenario bench for microcode_sequencer: a behavioural ROM, a byte feeder
// and a scoreboard of expected micro-op retirements.
module tb_microcode_sequencer;
  import microcode_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_valid, fetch_ready;
  logic [7:0]  fetch_data;
  logic [8:0]  uop_addr;
  logic [63:0] uop_ctrl;
  logic        uop_valid, stall;
  logic [15:0] imm;
  logic        instr_start, instr_done, wake;

  microcode_sequencer dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_data(fetch_data),
    .uop_addr(uop_addr), .uop_ctrl(uop_ctrl), .uop_valid(uop_valid), .stall(stall),
    .imm(imm), .instr_start(instr_start), .instr_done(instr_done), .wake(wake)
  );

  always #5 clk = ~clk;

  // Behavioural microcode ROM
  function automatic logic [63:0] rom(input logic [8:0] a);
    logic [63:0] w;
    w = '0;
    case (a)
      9'h001: begin w[53] = 1'b1; w[62:54] = 9'h101; end
      9'h101: begin w[53] = 1'b1; w[62:54] = 9'h102; end
      9'h002: w[62:54] = 9'h003;
      9'h076: begin w[52] = 1'b1; w[63] = 1'b1; end
      default: w[63] = 1'b1;
    endcase
    return w;
  endfunction

  assign uop_ctrl = rom(uop_addr);

  typedef struct {
    logic [8:0]  addr;
    logic [15:0] imm;
    logic        done;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] feed_q[$];
  bit         hold_ready;
  int         total, bad;
  exp_t       e;

  logic       o_fv, o_valid, o_start, o_done, o_retire;
  logic [8:0] o_addr;
  logic [15:0] o_imm;

  // One clock: drive inputs just after posedge, sample at negedge
  task automatic step();
    logic [7:0] b;
    fetch_ready = fetch_valid && (feed_q.size() != 0) && !hold_ready;
    fetch_data  = (feed_q.size() != 0) ? feed_q[0] : 8'h00;
    @(negedge clk);
    o_fv = fetch_valid; o_valid = uop_valid; o_start = instr_start;
    o_done = instr_done; o_addr = uop_addr; o_imm = imm;
    o_retire = uop_valid && !stall;
    @(posedge clk);
    if (fetch_ready) b = feed_q.pop_front();
    #1;
  endtask

  task automatic release_reset();
    stall = 0; wake = 0; hold_ready = 0; fetch_ready = 0; fetch_data = 0;
    feed_q.delete(); exp_q.delete();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    stall = 0; wake = 0; hold_ready = 0; fetch_ready = 0; fetch_data = 0;
    #2 rst = 1'b1;
    #1;
    total++;
    if (fetch_valid !== 0 || uop_valid !== 0 || uop_addr !== 9'h000 || imm !== 16'h0000 ||
        instr_start !== 0 || instr_done !== 0) begin
      bad++;
      $display("FAIL reset_values: fv=%b uv=%b addr=%h imm=%h st=%b dn=%b want all zero",
               fetch_valid, uop_valid, uop_addr, imm, instr_start, instr_done);
    end
    release_reset();
    step();
    total++;
    if (o_fv !== 1'b0) begin bad++; $display("FAIL reset_first_cycle_fv: got %b want 0", o_fv); end
    step();
    total++;
    if (o_fv !== 1'b1) begin bad++; $display("FAIL reset_second_cycle_fv: got %b want 1", o_fv); end
  endtask

  task automatic test_nop();
    feed_q.push_back(8'h00);
    exp_q.push_back('{addr: 9'h000, imm: 16'h0000, done: 1'b1});
    step();
    total++;
    if (o_fv !== 1 || o_start !== 1 || o_valid !== 0) begin
      bad++; $display("FAIL nop_fetch: fv=%b start=%b uv=%b want 1 1 0", o_fv, o_start, o_valid);
    end
    step();
    total++;
    if (!o_retire) begin
      bad++; $display("FAIL nop_retire_cycle: uop_valid=%b want 1", o_valid);
    end else begin
      e = exp_q.pop_front();
      if (o_addr !== e.addr || o_done !== e.done || o_fv !== 0) begin
        bad++; $display("FAIL nop_retire: addr=%h done=%b fv=%b want %h %b 0", o_addr, o_done, o_fv, e.addr, e.done);
      end
    end
    exp_q.delete();
    step();
    total++;
    if (o_fv !== 1) begin bad++; $display("FAIL nop_next_fetch: fv=%b want 1", o_fv); end
  endtask

  task automatic test_cb_prefix();
    feed_q.push_back(8'hCB); feed_q.push_back(8'h37);
    exp_q.push_back('{addr: 9'h137, imm: 16'h0000, done: 1'b1});
    step();
    total++;
    if (o_start !== 1) begin bad++; $display("FAIL cb_start_on_prefix: got %b want 1", o_start); end
    step();
    total++;
    if (o_fv !== 1 || o_start !== 0) begin
      bad++; $display("FAIL cb_second_byte: fv=%b start=%b want 1 0", o_fv, o_start);
    end
    step();
    total++;
    if (!o_retire) begin
      bad++; $display("FAIL cb_retire_cycle: uop_valid=%b want 1", o_valid);
    end else begin
      e = exp_q.pop_front();
      if (o_addr !== e.addr || o_done !== e.done) begin
        bad++; $display("FAIL cb_retire: addr=%h done=%b want %h %b", o_addr, o_done, e.addr, e.done);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_immediate();
    feed_q.push_back(8'h01); feed_q.push_back(8'h34); feed_q.push_back(8'h12);
    exp_q.push_back('{addr: 9'h001, imm: 16'h3400, done: 1'b0});
    exp_q.push_back('{addr: 9'h101, imm: 16'h1234, done: 1'b0});
    exp_q.push_back('{addr: 9'h102, imm: 16'h1234, done: 1'b1});
    for (int c = 0; c < 30 && exp_q.size() != 0; c++) begin
      step();
      if (o_retire) begin
        e = exp_q.pop_front();
        total++;
        if (o_addr !== e.addr || o_imm !== e.imm || o_done !== e.done) begin
          bad++;
          $display("FAIL imm_retire: addr=%h imm=%h done=%b want addr=%h imm=%h done=%b",
                   o_addr, o_imm, o_done, e.addr, e.imm, e.done);
        end
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL imm_timeout: missing=%0d want 0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_stall();
    feed_q.push_back(8'h02);
    exp_q.push_back('{addr: 9'h002, imm: 16'h0000, done: 1'b0});
    exp_q.push_back('{addr: 9'h003, imm: 16'h0000, done: 1'b1});
    stall = 1;  // must not affect the fetch
    step();
    total++;
    if (o_start !== 1) begin bad++; $display("FAIL stall_ignored_in_fetch: start=%b want 1", o_start); end
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if (o_valid !== 1 || o_addr !== 9'h002 || o_done !== 0) begin
        bad++; $display("FAIL stall_hold: uv=%b addr=%h done=%b want 1 002 0", o_valid, o_addr, o_done);
      end
    end
    stall = 0;
    for (int c = 0; c < 2; c++) begin
      step();
      total++;
      if (!o_retire) begin
        bad++; $display("FAIL stall_retire_cycle%0d: uop_valid=%b want 1", c, o_valid);
      end else begin
        e = exp_q.pop_front();
        if (o_addr !== e.addr || o_done !== e.done) begin
          bad++; $display("FAIL stall_retire: addr=%h done=%b want %h %b", o_addr, o_done, e.addr, e.done);
        end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_halt();
    feed_q.push_back(8'h76); feed_q.push_back(8'h00);
    step();
    step();
    total++;
    if (o_retire !== 1 || o_addr !== 9'h076 || o_done !== 1) begin
      bad++; $display("FAIL halt_retire: retire=%b addr=%h done=%b want 1 076 1", o_retire, o_addr, o_done);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      total++;
      if (o_fv !== 0 || o_valid !== 0) begin
        bad++; $display("FAIL halt_idle: fv=%b uv=%b want 0 0", o_fv, o_valid);
      end
    end
    wake = 1;
    step();
    wake = 0;
    hold_ready = 1;
    for (int c = 0; c < 5; c++) begin
      step();
      total++;
      if (o_fv !== 1 || o_start !== 0 || o_addr !== 9'h076) begin
        bad++; $display("FAIL halt_wait_ready: fv=%b start=%b addr=%h want 1 0 076", o_fv, o_start, o_addr);
      end
    end
    hold_ready = 0;
    step();
    total++;
    if (o_start !== 1) begin bad++; $display("FAIL wake_fetch: start=%b want 1", o_start); end
    step();
    total++;
    if (o_retire !== 1 || o_addr !== 9'h000 || o_done !== 1) begin
      bad++; $display("FAIL wake_retire: retire=%b addr=%h done=%b want 1 000 1", o_retire, o_addr, o_done);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    n = 0;
    feed_q.push_back(8'h00); feed_q.push_back(8'hCB); feed_q.push_back(8'h37); feed_q.push_back(8'h00);
    exp_q.push_back('{addr: 9'h000, imm: 16'h0000, done: 1'b1});
    exp_q.push_back('{addr: 9'h137, imm: 16'h0000, done: 1'b1});
    exp_q.push_back('{addr: 9'h000, imm: 16'h0000, done: 1'b1});
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
      step();
      n++;
      if (o_done) begin
        total++;
        if (o_fv !== 0) begin bad++; $display("FAIL b2b_done_overlap: fv=%b want 0", o_fv); end
      end
      if (o_retire) begin
        e = exp_q.pop_front();
        total++;
        if (o_addr !== e.addr || o_done !== e.done) begin
          bad++; $display("FAIL b2b_retire: addr=%h done=%b want %h %b", o_addr, o_done, e.addr, e.done);
        end
      end
    end
    total++;
    if (exp_q.size() != 0 || n != 7) begin
      bad++; $display("FAIL b2b_cycles: cycles=%0d missing=%0d want 7 0", n, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_imm();
    feed_q.push_back(8'h01); feed_q.push_back(8'h34);
    for (int c = 0; c < 6; c++) step();
    total++;
    if (o_fv !== 1 || o_imm !== 16'h3400 || o_addr !== 9'h101) begin
      bad++; $display("FAIL mid_imm_setup: fv=%b imm=%h addr=%h want 1 3400 101", o_fv, o_imm, o_addr);
    end
    rst = 1'b1;
    #1;
    total++;
    if (imm !== 16'h0000 || fetch_valid !== 0 || uop_valid !== 0 || uop_addr !== 9'h000 || instr_done !== 0) begin
      bad++; $display("FAIL mid_imm_reset: imm=%h fv=%b uv=%b addr=%h dn=%b want 0000 0 0 000 0",
                      imm, fetch_valid, uop_valid, uop_addr, instr_done);
    end
    release_reset();
    step();
    total++;
    if (o_fv !== 0 || o_done !== 0) begin bad++; $display("FAIL mid_imm_post: fv=%b dn=%b want 0 0", o_fv, o_done); end
    step();
    total++;
    if (o_fv !== 1 || o_imm !== 16'h0000) begin
      bad++; $display("FAIL mid_imm_restart: fv=%b imm=%h want 1 0000", o_fv, o_imm);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset();
    test_nop();
    test_cb_prefix();
    test_immediate();
    test_stall();
    test_halt();
    test_back_to_back();
    test_reset_mid_imm();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
